// File: rtl/tdm_demux.sv
// Time-division demultiplexer: gathers one W-bit sample per slot from a single lane
// and publishes a complete N_CH-channel frame as one parallel word.
module tdm_demux #(
   parameter int N_CH = 4,
   parameter int W    = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [W-1:0]              din,
   input  logic                      din_valid,
   input  logic                      frame,
   output logic [N_CH*W-1:0]         dout,
   output logic                      dout_valid,
   output logic [$clog2(N_CH)-1:0]   slot,
   output logic                      sync_err
);

   // Handshake: din_valid qualifies din and frame for one cycle; there is no
   // backpressure, so every valid sample is consumed on the edge it is presented.
   localparam int SW = $clog2(N_CH);
   localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t state;

   // The top channel never needs a shadow: it goes straight from din into dout.
   logic [W-1:0] shadow [N_CH-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         slot       <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         sync_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (din_valid && frame) begin
                  shadow[0] <= din;
                  slot      <= SW'(1);
                  state     <= COLLECT;
               end
            end
            COLLECT: begin
               if (din_valid) begin
                  if (frame) begin
                     // Slot is never 0 while collecting, so a marker here is always early.
                     sync_err  <= 1'b1;
                     shadow[0] <= din;
                     slot      <= SW'(1);
                  end else if (slot == LAST_SLOT) begin
                     for (int k = 0; k < N_CH - 1; k++) begin
                        dout[k*W +: W] <= shadow[k];
                     end
                     dout[(N_CH-1)*W +: W] <= din;
                     dout_valid <= 1'b1;
                     slot       <= '0;
                     state      <= IDLE;
                  end else begin
                     shadow[slot] <= din;
                     slot         <= slot + SW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed scenarios plus randomized traffic, each checked
// against a queue-based model of frame assembly.
module tb_tdm_demux;

   localparam int N_CH = 4;
   localparam int W    = 8;
   localparam int SW   = $clog2(N_CH);

   logic                  clk;
   logic                  reset;
   logic [W-1:0]          din;
   logic                  din_valid;
   logic                  frame;
   logic [N_CH*W-1:0]     dout;
   logic                  dout_valid;
   logic [SW-1:0]         slot;
   logic                  sync_err;

   int total;
   int bad;

   // reference model state
   logic [W-1:0]          col_q[$];
   logic [N_CH*W-1:0]     exp_q[$];
   logic [N_CH*W-1:0]     m_dout;
   logic                  m_valid;
   logic                  m_err;
   logic [SW-1:0]         m_slot;

   tdm_demux #(.N_CH(N_CH), .W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .frame      (frame),
      .dout       (dout),
      .dout_valid (dout_valid),
      .slot       (slot),
      .sync_err   (sync_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // driver: present one cycle of input, advance the model, settle 1 time unit past the edge
   task automatic step(input logic v, input logic f, input logic [W-1:0] d);
      din       = d;
      din_valid = v;
      frame     = f;
      @(posedge clk);
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (reset) begin
         col_q.delete();
         m_dout = '0;
      end else if (v) begin
         if (f) begin
            if (col_q.size() != 0) m_err = 1'b1;
            col_q.delete();
            col_q.push_back(d);
         end else if (col_q.size() != 0) begin
            col_q.push_back(d);
            if (col_q.size() == N_CH) begin
               for (int k = 0; k < N_CH; k++) m_dout[k*W +: W] = col_q[k];
               m_valid = 1'b1;
               exp_q.push_back(m_dout);
               col_q.delete();
            end
         end
      end
      m_slot = SW'(col_q.size());
      #1;
      din_valid = 1'b0;
      frame     = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(1'b0, 1'b0, '0);
      step(1'b1, 1'b1, 8'h5A);
      reset = 1'b0;
      total++;
      if (dout !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=%h", dout, 32'h0); end
      total++;
      if (dout_valid !== 1'b0 || sync_err !== 1'b0) begin
         bad++; $display("FAIL reset_pulses got=%b%b exp=00", dout_valid, sync_err);
      end
      total++;
      if (slot !== 2'd0) begin bad++; $display("FAIL reset_slot got=%0d exp=0", slot); end
   endtask

   task automatic test_basic();
      logic [W-1:0] s [4];
      logic [SW-1:0] es [4];
      s  = '{8'h11, 8'h22, 8'h33, 8'h44};
      es = '{2'd1, 2'd2, 2'd3, 2'd0};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, (i == 0), s[i]);
         total++;
         if (slot !== es[i]) begin bad++; $display("FAIL basic_slot%0d got=%0d exp=%0d", i, slot, es[i]); end
         total++;
         if (dout_valid !== (i == 3)) begin
            bad++; $display("FAIL basic_valid%0d got=%b exp=%b", i, dout_valid, (i == 3));
         end
      end
      total++;
      if (dout !== 32'h44332211) begin bad++; $display("FAIL basic_dout got=%h exp=44332211", dout); end
      step(1'b0, 1'b0, '0);
      total++;
      if (dout_valid !== 1'b0 || dout !== 32'h44332211) begin
         bad++; $display("FAIL basic_hold got=%b/%h exp=0/44332211", dout_valid, dout);
      end
   endtask

   task automatic test_gaps();
      int pulses;
      pulses = 0;
      step(1'b1, 1'b0, 8'hEE);
      total++;
      if (slot !== 2'd0 || dout_valid !== 1'b0 || sync_err !== 1'b0) begin
         bad++; $display("FAIL gaps_stray got=slot%0d v%b e%b exp=slot0 v0 e0", slot, dout_valid, sync_err);
      end
      step(1'b1, 1'b1, 8'hA0); pulses += dout_valid;
      for (int i = 0; i < 3; i++) begin step(1'b0, 1'b0, 8'hFF); pulses += dout_valid; end
      total++;
      if (slot !== 2'd1) begin bad++; $display("FAIL gaps_slot_hold got=%0d exp=1", slot); end
      step(1'b1, 1'b0, 8'hA1); pulses += dout_valid;
      step(1'b0, 1'b0, 8'hFF); pulses += dout_valid;
      step(1'b1, 1'b0, 8'hA2); pulses += dout_valid;
      step(1'b1, 1'b0, 8'hA3); pulses += dout_valid;
      total++;
      if (dout !== 32'hA3A2A1A0) begin bad++; $display("FAIL gaps_dout got=%h exp=A3A2A1A0", dout); end
      step(1'b0, 1'b0, '0); pulses += dout_valid;
      total++;
      if (pulses != 1) begin bad++; $display("FAIL gaps_pulses got=%0d exp=1", pulses); end
   endtask

   task automatic test_early();
      int errs;
      errs = 0;
      for (int i = 0; i < 4; i++) step(1'b1, (i == 0), W'(i + 1));
      total++;
      if (dout !== 32'h04030201) begin bad++; $display("FAIL early_first got=%h exp=04030201", dout); end
      step(1'b1, 1'b1, 8'h10); errs += sync_err;
      step(1'b1, 1'b0, 8'h20); errs += sync_err;
      step(1'b1, 1'b1, 8'h30);
      total++;
      if (sync_err !== 1'b1 || slot !== 2'd1) begin
         bad++; $display("FAIL early_err got=e%b slot%0d exp=e1 slot1", sync_err, slot);
      end
      errs += sync_err;
      step(1'b1, 1'b0, 8'h40); errs += sync_err;
      step(1'b1, 1'b0, 8'h50); errs += sync_err;
      total++;
      if (dout !== 32'h04030201 || dout_valid !== 1'b0) begin
         bad++; $display("FAIL early_hold got=%h/%b exp=04030201/0", dout, dout_valid);
      end
      step(1'b1, 1'b0, 8'h60); errs += sync_err;
      total++;
      if (dout !== 32'h60504030 || dout_valid !== 1'b1) begin
         bad++; $display("FAIL early_dout got=%h/%b exp=60504030/1", dout, dout_valid);
      end
      total++;
      if (errs != 1) begin bad++; $display("FAIL early_errcount got=%0d exp=1", errs); end
   endtask

   task automatic test_back_to_back();
      logic [N_CH*W-1:0] want [3];
      int pulses, errs;
      want = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
      pulses = 0;
      errs = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, (i % 4 == 0), W'(i));
         errs += sync_err;
         if (dout_valid) begin
            total++;
            if (pulses > 2 || dout !== want[pulses > 2 ? 2 : pulses]) begin
               bad++; $display("FAIL b2b_dout%0d got=%h exp=%h", pulses, dout, want[pulses > 2 ? 2 : pulses]);
            end
            pulses++;
         end
      end
      total++;
      if (pulses != 3 || errs != 0) begin
         bad++; $display("FAIL b2b_counts got=v%0d e%0d exp=v3 e0", pulses, errs);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b1, 8'h55);
      step(1'b1, 1'b0, 8'h66);
      reset = 1'b1;
      step(1'b0, 1'b0, '0);
      reset = 1'b0;
      total++;
      if (dout !== 32'h0 || slot !== 2'd0 || dout_valid !== 1'b0 || sync_err !== 1'b0) begin
         bad++; $display("FAIL rstmid_state got=%h slot%0d v%b e%b exp=0 slot0 v0 e0", dout, slot, dout_valid, sync_err);
      end
      for (int i = 0; i < 4; i++) step(1'b1, (i == 0), W'(i + 1));
      total++;
      if (dout !== 32'h04030201 || dout_valid !== 1'b1) begin
         bad++; $display("FAIL rstmid_next got=%h/%b exp=04030201/1", dout, dout_valid);
      end
   endtask

   task automatic test_frame_gap();
      step(1'b1, 1'b1, 8'h77);
      step(1'b0, 1'b1, 8'h99);
      total++;
      if (sync_err !== 1'b0 || slot !== 2'd1) begin
         bad++; $display("FAIL fgap_noeffect got=e%b slot%0d exp=e0 slot1", sync_err, slot);
      end
      step(1'b1, 1'b0, 8'h78);
      step(1'b1, 1'b0, 8'h79);
      step(1'b1, 1'b0, 8'h7A);
      total++;
      if (dout !== 32'h7A797877) begin bad++; $display("FAIL fgap_dout got=%h exp=7A797877", dout); end
   endtask

   task automatic test_random();
      logic [N_CH*W-1:0] e;
      exp_q.delete();
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2), W'($urandom_range(0, 255)));
         total++;
         if (dout !== m_dout || dout_valid !== m_valid || sync_err !== m_err || slot !== m_slot) begin
            bad++;
            $display("FAIL rand_cyc%0d got=%h v%b e%b s%0d exp=%h v%b e%b s%0d",
                     i, dout, dout_valid, sync_err, slot, m_dout, m_valid, m_err, m_slot);
         end
         if (dout_valid) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            total++;
            if (dout !== e) begin bad++; $display("FAIL rand_sb got=%h exp=%h", dout, e); end
         end
      end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      m_dout = '0;
      m_valid = 1'b0;
      m_err = 1'b0;
      m_slot = '0;
      reset = 1'b0;
      din = '0;
      din_valid = 1'b0;
      frame = 1'b0;
      test_reset();
      test_basic();
      test_gaps();
      test_early();
      test_back_to_back();
      test_reset_mid();
      test_frame_gap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
